result_writer: RTL and testbench



---
 rtl/minilab_pkg.sv | 21 ++
 rtl/result_packer.sv | 26 ++
 rtl/result_writer.sv | 135 +++++++++++++
 tb/tb_result_writer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minilab_pkg.sv
// Shared types and constants for the result writer slice.
// Holds the writer FSM encoding and Avalon-MM data constants.
package minilab_pkg;

  // S_CKSUM keeps its code even when the checksum beat is compiled out,
  // so dbg_state decodes the same in every build.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CKSUM = 2'd2,
    S_DONE  = 2'd3
  } wr_state_t;

  localparam int         AVM_DATA_WIDTH = 64;
  localparam logic [7:0] AVM_BE_ALL     = 8'hFF;

  function automatic int words_for(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/result_packer.sv
// Combinational lane packer: two zero-extended lanes per 64-bit word.
// Ports: lanes (snapshot array), idx (word index) -> data (word idx).
module result_packer
  import minilab_pkg::*;
#(
  parameter int N         = 8,
  parameter int RES_WIDTH = 24,
  parameter int KW        = 2
) (
  input  logic [RES_WIDTH-1:0]      lanes [N],
  input  logic [KW-1:0]             idx,
  output logic [AVM_DATA_WIDTH-1:0] data
);

  // Lane 2k lands in the low half, lane 2k+1 in the high half.
  // A missing odd lane simply leaves the high half at zero.
  always_comb begin
    data = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == KW'(i / 2)) begin
        data[32*(i%2) +: 32] = 32'(lanes[i]);
      end
    end
  end

endmodule

// File: rtl/result_writer.sv
// Avalon-MM write master that snapshots N lane results and writes
// them as ceil(N/2) packed 64-bit single-beat writes from base_addr.
// Ports: clk, rst (sync, active-high), start, base_addr, c_in[N];
//   busy, done, avm_* write master, dbg_state (FSM encoding).
// Option: RESULT_WRITER_CHECKSUM_EN adds a final checksum beat.
module result_writer
  import minilab_pkg::*;
#(
  parameter int N          = 8,
  parameter int RES_WIDTH  = 24,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [RES_WIDTH-1:0]      c_in [N],
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH-1:0]     avm_address,
  output logic                      avm_write,
  output logic [AVM_DATA_WIDTH-1:0] avm_writedata,
  output logic [7:0]                avm_byteenable,
  input  logic                      avm_waitrequest,
  output logic [1:0]                dbg_state
);

  localparam int NWORDS = words_for(N);
  localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

`ifdef RESULT_WRITER_CHECKSUM_EN
  localparam wr_state_t AFTER_DATA = S_CKSUM;
`else
  localparam wr_state_t AFTER_DATA = S_DONE;
`endif

  wr_state_t             state;
  wr_state_t             state_nx;
  logic [RES_WIDTH-1:0]  snap [N];
  logic [ADDR_WIDTH-1:0] base_q;
  logic [KW-1:0]         k;
  logic [AVM_DATA_WIDTH-1:0] word;
  logic                  take;
  logic                  last;
  logic                  accept;

  // A start is only honoured when no transfer is in flight.
  assign take   = start && (state == S_IDLE || state == S_DONE);
  assign last   = (k == KW'(NWORDS - 1));
  assign accept = avm_write && !avm_waitrequest;

  assign avm_byteenable = AVM_BE_ALL;
  assign dbg_state      = state;

  result_packer #(
    .N         (N),
    .RES_WIDTH (RES_WIDTH),
    .KW        (KW)
  ) u_packer (
    .lanes (snap),
    .idx   (k),
    .data  (word)
  );

`ifdef RESULT_WRITER_CHECKSUM_EN
  logic [31:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + 32'(snap[i]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      base_q <= '0;
      k      <= '0;
      for (int i = 0; i < N; i++) begin
        snap[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (take) begin
        snap   <= c_in;
        base_q <= base_addr;
        k      <= '0;
      end else if (state == S_WRITE && accept && !last) begin
        k <= k + 1'b1;
      end
    end
  end

  // Bus outputs are zero outside the write states, so a stalled beat
  // is held purely by the state and counter staying put.
  always_comb begin
    state_nx      = state;
    busy          = 1'b0;
    done          = 1'b0;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_WRITE;
      end
      S_WRITE: begin
        busy          = 1'b1;
        avm_write     = 1'b1;
        avm_address   = base_q + ADDR_WIDTH'(k);
        avm_writedata = word;
        if (!avm_waitrequest && last) state_nx = AFTER_DATA;
      end
      S_CKSUM: begin
`ifdef RESULT_WRITER_CHECKSUM_EN
        busy          = 1'b1;
        avm_write     = 1'b1;
        avm_address   = base_q + ADDR_WIDTH'(NWORDS);
        avm_writedata = {32'h0, sum};
        if (!avm_waitrequest) state_nx = S_DONE;
`else
        state_nx = S_IDLE;
`endif
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nx = S_WRITE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer (N=8 main DUT, N=3 odd DUT).
// Transaction-level model checks every cycle; directed tests pin it.
module tb_result_writer;
  import minilab_pkg::*;

  localparam int N  = 8;
  localparam int RW = 24;
  localparam int AW = 32;
  localparam int NW = 4;
`ifdef RESULT_WRITER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          wr_wait = 1'b0;
  logic [AW-1:0] base = '0;
  logic [RW-1:0] c_in [N];
  logic          busy, done, avm_write;
  logic [AW-1:0] addr;
  logic [63:0]   data;
  logic [7:0]    be;
  logic [1:0]    dbg;

  logic          start3 = 1'b0;
  logic [AW-1:0] base3 = '0;
  logic [RW-1:0] c3 [3];
  logic          busy3, done3, w3;
  logic [AW-1:0] a3;
  logic [63:0]   d3;
  logic [7:0]    be3;
  logic [1:0]    dbg3;

  result_writer #(.N(N), .RES_WIDTH(RW), .ADDR_WIDTH(AW)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr       (base),
    .c_in            (c_in),
    .busy            (busy),
    .done            (done),
    .avm_address     (addr),
    .avm_write       (avm_write),
    .avm_writedata   (data),
    .avm_byteenable  (be),
    .avm_waitrequest (wr_wait),
    .dbg_state       (dbg)
  );

  result_writer #(.N(3), .RES_WIDTH(RW), .ADDR_WIDTH(AW)) u_dut3 (
    .clk             (clk),
    .rst             (rst),
    .start           (start3),
    .base_addr       (base3),
    .c_in            (c3),
    .busy            (busy3),
    .done            (done3),
    .avm_address     (a3),
    .avm_write       (w3),
    .avm_writedata   (d3),
    .avm_byteenable  (be3),
    .avm_waitrequest (1'b0),
    .dbg_state       (dbg3)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Transaction model: list of expected beats built at start time.
  bit            armed = 1'b0;
  bit            m_act = 1'b0;
  bit            m_done = 1'b0;
  int            m_idx = 0;
  logic [AW-1:0] m_base = '0;
  logic [63:0]   m_words [$];
  logic [AW-1:0] log_a [$];
  logic [63:0]   log_d [$];

  function automatic void build();
    logic [31:0] lo, hi, sum;
    m_words.delete();
    sum = 32'h0;
    for (int kk = 0; kk < NW; kk++) begin
      lo = 32'(c_in[2*kk]);
      hi = (2*kk + 1 < N) ? 32'(c_in[2*kk+1]) : 32'h0;
      m_words.push_back({hi, lo});
    end
    for (int i = 0; i < N; i++) sum = sum + 32'(c_in[i]);
    if (CK) m_words.push_back({32'h0, sum});
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 64'(busy), 64'(m_act));
      chk("done", 64'(done), 64'(m_done));
      chk("avm_write", 64'(avm_write), 64'(m_act));
      chk("byteenable", 64'(be), 64'hFF);
      if (m_act) begin
        chk("avm_address", 64'(addr), 64'(m_base + AW'(m_idx)));
        chk("avm_writedata", data, m_words[m_idx]);
      end
    end
    if (avm_write && !wr_wait) begin
      log_a.push_back(addr);
      log_d.push_back(data);
    end
    if (rst) begin
      m_act  = 1'b0;
      m_done = 1'b0;
      armed  = 1'b1;
    end else if (start && !m_act) begin
      build();
      m_base = base;
      m_idx  = 0;
      m_act  = 1'b1;
      m_done = 1'b0;
    end else if (m_act && !wr_wait) begin
      m_idx++;
      if (m_idx == m_words.size()) begin
        m_act  = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [AW-1:0] b);
    base  = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Returns the cycle (start cycle = 0) in which done is first seen.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 60) begin
      step();
      cyc++;
    end
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  task automatic ramp();
    for (int i = 0; i < N; i++) c_in[i] = RW'(32'h100 * i + i);
  endtask

  int cyc;
  logic [63:0] d3_log [$];

  initial begin
    ramp();
    c3[0] = 24'h1;
    c3[1] = 24'h2;
    c3[2] = 24'h3;
    step();
    step();
    chk("rst_address", 64'(addr), 64'h0);
    chk("rst_writedata", data, 64'h0);
    chk("rst_state", 64'(dbg), 64'(S_IDLE));
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_write", 64'(avm_write), 64'h0);
    rst = 1'b0;
    step();

    // Basic 4-beat transfer, no stalls.
    clear_log();
    pulse(32'h40);
    wait_done(1, cyc);
    chk("t1_done_cycle", 64'(cyc), CK ? 64'd6 : 64'd5);
    chk("t1_beats", 64'(log_a.size()), CK ? 64'd5 : 64'd4);
    chk("t1_addr0", 64'(log_a[0]), 64'h40);
    chk("t1_addr3", 64'(log_a[3]), 64'h43);
    chk("t1_data0", log_d[0], 64'h00000101_00000000);
    chk("t1_data3", log_d[3], 64'h00000707_00000606);
    step();
    chk("t1_busy_after", 64'(busy), 64'h0);

    // Restart from S_DONE, beat 1 stalled for 3 cycles.
    clear_log();
    pulse(32'h40);
    step();
    chk("t2_stall_addr", 64'(addr), 64'h41);
    wr_wait = 1'b1;
    step();
    step();
    step();
    chk("t2_hold_addr", 64'(addr), 64'h41);
    chk("t2_hold_data", data, 64'h00000303_00000202);
    wr_wait = 1'b0;
    wait_done(5, cyc);
    chk("t2_done_cycle", 64'(cyc), CK ? 64'd9 : 64'd8);
    chk("t2_beats", 64'(log_a.size()), CK ? 64'd5 : 64'd4);

    // Input change and second start during transfer are ignored.
    clear_log();
    pulse(32'h40);
    for (int i = 0; i < N; i++) c_in[i] = 24'hFFFFFF;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(3, cyc);
    chk("t3_done_cycle", 64'(cyc), CK ? 64'd6 : 64'd5);
    chk("t3_beats", 64'(log_a.size()), CK ? 64'd5 : 64'd4);
    chk("t3_data1", log_d[1], 64'h00000303_00000202);
    chk("t3_data3", log_d[3], 64'h00000707_00000606);
    ramp();
    step();

    // Reset during beat 2, then a fresh transfer at 0x80.
    pulse(32'h40);
    step();
    step();
    chk("t4_beat2_addr", 64'(addr), 64'h42);
    rst = 1'b1;
    step();
    chk("t4_rst_write", 64'(avm_write), 64'h0);
    chk("t4_rst_busy", 64'(busy), 64'h0);
    chk("t4_rst_done", 64'(done), 64'h0);
    rst = 1'b0;
    step();
    clear_log();
    pulse(32'h80);
    wait_done(1, cyc);
    chk("t4_done_cycle", 64'(cyc), CK ? 64'd6 : 64'd5);
    chk("t4_beats", 64'(log_a.size()), CK ? 64'd5 : 64'd4);
    chk("t4_addr0", 64'(log_a[0]), 64'h80);
    chk("t4_addr3", 64'(log_a[3]), 64'h83);
    step();

    // All-ones lanes: checksum beat when enabled.
    for (int i = 0; i < N; i++) c_in[i] = 24'hFFFFFF;
    clear_log();
    pulse(32'h10);
    wait_done(1, cyc);
    chk("t5_data0", log_d[0], 64'h00FFFFFF_00FFFFFF);
    if (CK) begin
      chk("t5_beats", 64'(log_a.size()), 64'd5);
      chk("t5_ck_addr", 64'(log_a[4]), 64'h14);
      chk("t5_ck_data", log_d[4], 64'h00000000_07FFFFF8);
      chk("t5_done_cycle", 64'(cyc), 64'd6);
    end else begin
      chk("t5_beats", 64'(log_a.size()), 64'd4);
      chk("t5_done_cycle", 64'(cyc), 64'd5);
    end
    step();

    // Odd lane count on the N=3 instance.
    base3  = '0;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (w3) d3_log.push_back(d3);
      if (done3) break;
      step();
    end
    chk("t6_done", 64'(done3), 64'h1);
    chk("t6_be", 64'(be3), 64'hFF);
    chk("t6_beats", 64'(d3_log.size()), CK ? 64'd3 : 64'd2);
    chk("t6_data0", d3_log[0], 64'h00000002_00000001);
    chk("t6_data1", d3_log[1], 64'h00000000_00000003);
    if (CK) chk("t6_ck", d3_log[2], 64'h00000000_00000006);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
